// File: rtl/data_mem_ctrl.sv
// RV32IM MEM-stage data memory with byte/half/word access, configurable latency and BUSY/READY handshake.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned accesses instead of forcing alignment.
module data_mem_ctrl #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    input  logic [2:0]            FUNCT3,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [31:0]           DATA_IN,
    output logic [31:0]           DATA_OUT,
    output logic                  BUSY,
    output logic                  READY,
    output logic                  MISALIGNED
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LOW_W = IDX_W + 2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      mem [DEPTH];

    logic [LOW_W-1:0] lat_addr;
    logic [2:0]       lat_funct3;
    logic [31:0]      lat_data;
    logic             lat_read;
    logic             lat_write;

    logic             request;
    logic             do_access;
    logic [LOW_W-1:0] acc_addr;
    logic [2:0]       acc_funct3;
    logic [31:0]      acc_data;
    logic             acc_read;
    logic             acc_write;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_word;

    logic             is_byte;
    logic             is_half;
    logic             is_word;
    logic             sign_ext;
    logic [1:0]       offset;
    logic             misaligned;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
    logic             unused_addr;

    assign request     = MEM_READ | MEM_WRITE;
    assign unused_addr = ^ADDR[ADDR_WIDTH-1:LOW_W];

    // In IDLE the access (if immediate) uses the live inputs; later states use the latched copy.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        acc_addr   = lat_addr;
        acc_funct3 = lat_funct3;
        acc_data   = lat_data;
        acc_read   = lat_read;
        acc_write  = lat_write;
        if (state == IDLE) begin
            acc_addr   = ADDR[LOW_W-1:0];
            acc_funct3 = FUNCT3;
            acc_data   = DATA_IN;
            acc_read   = MEM_READ;
            acc_write  = MEM_WRITE;
        end
    end

    assign acc_idx  = acc_addr[LOW_W-1:2];
    assign acc_word = mem[acc_idx];

    always_comb begin
        is_byte    = 1'b0;
        is_half    = 1'b0;
        is_word    = 1'b0;
        sign_ext   = 1'b0;
        offset     = acc_addr[1:0];
        misaligned = 1'b0;
        wr_mask    = 4'b0000;
        wr_data    = acc_data;
        load_val   = 32'h0;

        // Unsigned sizes exist only for loads; a write always wins over a read.
        case (acc_funct3)
            3'b000: begin is_byte = 1'b1; sign_ext = 1'b1; end
            3'b001: begin is_half = 1'b1; sign_ext = 1'b1; end
            3'b010: is_word = 1'b1;
            3'b100: is_byte = ~acc_write;
            3'b101: is_half = ~acc_write;
            default: ;
        endcase

`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned = (is_half & offset[0]) | (is_word & (offset != 2'b00));
`else
        if (is_half) offset[0] = 1'b0;
        if (is_word) offset = 2'b00;
`endif

        if (acc_write && !misaligned) begin
            if (is_byte) begin
                wr_mask = 4'b0001 << offset;
                wr_data = {4{acc_data[7:0]}};
            end else if (is_half) begin
                wr_mask = offset[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_data[15:0]}};
            end else if (is_word) begin
                wr_mask = 4'b1111;
            end
        end

        rd_byte = acc_word[{offset, 3'b000} +: 8];
        rd_half = acc_word[{offset[1], 4'b0000} +: 16];
        if (!misaligned) begin
            if (is_byte)      load_val = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            else if (is_half) load_val = {{16{sign_ext & rd_half[15]}}, rd_half};
            else if (is_word) load_val = acc_word;
        end
    end

    always_comb begin
        BUSY      = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                BUSY      = (LATENCY > 0) && request;
                do_access = (LATENCY <= 1) && request;
            end
            WAIT: begin
                BUSY      = 1'b1;
                do_access = (counter == CNT_W'(1));
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            counter    <= '0;
            DATA_OUT   <= 32'h0;
            READY      <= 1'b0;
            MISALIGNED <= 1'b0;
            lat_addr   <= '0;
            lat_funct3 <= 3'b000;
            lat_data   <= 32'h0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            // NOTE: the array is cleared on reset so loads after reset read zero; this keeps it in flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else begin
            READY      <= do_access;
            MISALIGNED <= do_access & misaligned;
            if (do_access) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_mask[b]) mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
                if (acc_read && !acc_write) DATA_OUT <= load_val;
            end

            case (state)
                IDLE: begin
                    if (request && LATENCY > 0) begin
                        lat_addr   <= ADDR[LOW_W-1:0];
                        lat_funct3 <= FUNCT3;
                        lat_data   <= DATA_IN;
                        lat_read   <= MEM_READ;
                        lat_write  <= MEM_WRITE;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            counter <= CNT_W'(LATENCY - 1);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (counter == CNT_W'(1)) state <= DONE;
                    else counter <= counter - 1'b1;
                end
                // The stalled pipeline advances on this edge, so the held request is not re-issued.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-array reference model, per-cycle compare, directed vectors.
module tb_data_mem_ctrl;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int MEMB  = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR, DATA_IN, DATA_OUT;
    logic        BUSY, READY, MISALIGNED;

    logic        r0, w0;
    logic [2:0]  f0;
    logic [31:0] a0, d0, dout0;
    logic        busy0, ready0, mis0;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .BUSY(BUSY), .READY(READY), .MISALIGNED(MISALIGNED)
    );

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(0), .ADDR_WIDTH(32)) dut0 (
        .CLK(CLK), .RESET(RESET), .MEM_READ(r0), .MEM_WRITE(w0),
        .FUNCT3(f0), .ADDR(a0), .DATA_IN(d0), .DATA_OUT(dout0),
        .BUSY(busy0), .READY(ready0), .MISALIGNED(mis0)
    );

    int passed = 0;
    int total  = 0;
    logic cmp_en = 1'b0;

    logic        exp_busy, exp_ready, exp_mis;
    logic [31:0] exp_dout;
    logic        exp0_ready;
    logic [31:0] exp0_dout;
    logic [7:0]  mbytes [MEMB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        else passed++;
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("busy", {31'b0, BUSY}, {31'b0, exp_busy});
            check("ready", {31'b0, READY}, {31'b0, exp_ready});
            check("misaligned", {31'b0, MISALIGNED}, {31'b0, exp_mis});
            check("data_out", DATA_OUT, exp_dout);
            check("busy0", {31'b0, busy0}, 32'h0);
            check("ready0", {31'b0, ready0}, {31'b0, exp0_ready});
            check("misaligned0", {31'b0, mis0}, 32'h0);
            check("data_out0", dout0, exp0_dout);
        end
    end

    function automatic int access_size(input logic [2:0] f3, input logic is_store);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return is_store ? 0 : 1;
            3'b101:  return is_store ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned base);
        int sz;
        logic [31:0] v;
        sz = access_size(f3, 1'b0);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mbytes[(base + i) % MEMB]) << (8 * i));
        if (sz > 0 && sz < 4 && f3[2] == 1'b0 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MEMB; i++) mbytes[i] = 8'h00;
        exp_dout  = 32'h0;
        exp0_dout = 32'h0;
    endtask

    // One pipeline access: request held while stalled and through DONE, then dropped.
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] din);
        int          sz;
        int unsigned base;
        logic        mis;
        logic [31:0] res;
        sz   = access_size(f3, wr);
        base = addr % MEMB;
        mis  = CHECK_EN && sz > 1 && (base % sz) != 0;
        if (sz > 1) base = base - (base % sz);
        res  = 32'h0;
        if (wr) begin
            if (!mis) for (int i = 0; i < sz; i++) mbytes[(base + i) % MEMB] = din[8*i +: 8];
        end else if (!mis) begin
            res = model_load(f3, base);
        end

        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDR = addr; DATA_IN = din;
        exp_busy = 1'b1;
        @(posedge CLK); #1;
        ADDR = ~addr; DATA_IN = ~din; FUNCT3 = ~f3;
        repeat (LAT - 1) @(posedge CLK);
        #1;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_mis   = mis;
        if (rd && !wr) exp_dout = res;
        @(posedge CLK); #1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        exp_ready = 1'b0;
        exp_mis   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'b000; ADDR = 32'h0; DATA_IN = 32'h0;
        r0 = 1'b0; w0 = 1'b0; f0 = 3'b000; a0 = 32'h0; d0 = 32'h0;
        exp_busy = 1'b0; exp_ready = 1'b0; exp_mis = 1'b0; exp0_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        cmp_en = 1'b1;
        check("reset_data_out", DATA_OUT, 32'h0);
        check("reset_ready", {31'b0, READY}, 32'h0);
        check("reset_busy", {31'b0, BUSY}, 32'h0);

        op(1'b1, 1'b0, LW, 32'd0, 32'h0);
        check("lw_0_after_reset", DATA_OUT, 32'h0000_0000);

        op(1'b0, 1'b1, LW, 32'd40, 32'h8899AABB);
        op(1'b1, 1'b0, LB, 32'd41, 32'h0);   check("lb_41", DATA_OUT, 32'hFFFF_FFAA);
        op(1'b1, 1'b0, LBU, 32'd41, 32'h0);  check("lbu_41", DATA_OUT, 32'h0000_00AA);
        op(1'b1, 1'b0, LH, 32'd42, 32'h0);   check("lh_42", DATA_OUT, 32'hFFFF_8899);
        op(1'b1, 1'b0, LHU, 32'd42, 32'h0);  check("lhu_42", DATA_OUT, 32'h0000_8899);
        op(1'b1, 1'b0, LW, 32'd40, 32'h0);   check("lw_40", DATA_OUT, 32'h8899_AABB);

        op(1'b0, 1'b1, LB, 32'd43, 32'h0000_0012);
        check("sb_keeps_data_out", DATA_OUT, 32'h8899_AABB);
        op(1'b1, 1'b0, LW, 32'd40, 32'h0);   check("lw_after_sb", DATA_OUT, 32'h1299_AABB);
        op(1'b0, 1'b1, LH, 32'd40, 32'h0000_3344);
        op(1'b1, 1'b0, LW, 32'd40, 32'h0);   check("lw_after_sh", DATA_OUT, 32'h1299_3344);

        op(1'b1, 1'b1, LW, 32'd12, 32'hA5A5_A5A5);
        check("read_write_keeps_data_out", DATA_OUT, 32'h1299_3344);
        op(1'b1, 1'b0, LW, 32'd12, 32'h0);   check("lw_12", DATA_OUT, 32'hA5A5_A5A5);
        op(1'b1, 1'b0, 3'b011, 32'd40, 32'h0); check("load_bad_funct3", DATA_OUT, 32'h0);
        op(1'b0, 1'b1, 3'b011, 32'd40, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, LW, 32'd40, 32'h0);   check("store_bad_funct3", DATA_OUT, 32'h1299_3344);
        op(1'b1, 1'b0, LH, 32'd43, 32'h0);
        check("lh_43", DATA_OUT, CHECK_EN ? 32'h0 : 32'h0000_1299);

        op(1'b0, 1'b1, LW, 32'h400, 32'h0000_0055);
        op(1'b1, 1'b0, LW, 32'h000, 32'h0);  check("wrap_lw_0", DATA_OUT, 32'h0000_0055);

        op(1'b0, 1'b1, LW, 32'd0, 32'hCAFE_F00D);
        op(1'b1, 1'b0, LW, 32'd2, 32'h0);
        check("lw_2", DATA_OUT, CHECK_EN ? 32'h0 : 32'hCAFE_F00D);

        MEM_WRITE = 1'b1; FUNCT3 = LW; ADDR = 32'd8; DATA_IN = 32'hDEAD_BEEF;
        exp_busy = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1; MEM_WRITE = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_busy = 1'b0;
        clear_model();
        check("abort_busy", {31'b0, BUSY}, 32'h0);
        check("abort_ready", {31'b0, READY}, 32'h0);
        check("abort_data_out", DATA_OUT, 32'h0);
        op(1'b1, 1'b0, LW, 32'd8, 32'h0);    check("abort_lw_8", DATA_OUT, 32'h0);

        w0 = 1'b1; f0 = LW; a0 = 32'd4; d0 = 32'h0000_1234;
        @(posedge CLK); #1;
        w0 = 1'b0; r0 = 1'b1; d0 = 32'h0;
        exp0_ready = 1'b1;
        check("l0_sw_keeps_data_out", dout0, 32'h0);
        @(posedge CLK); #1;
        r0 = 1'b0;
        exp0_dout = 32'h0000_1234;
        check("l0_lw_4", dout0, 32'h0000_1234);
        @(posedge CLK); #1;
        exp0_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised RV32IM data memory for the MEM stage; successor to the single-cycle word-only Data_Memory.
- Adds byte/halfword/word loads and stores selected by funct3, with sign/zero extension.
- Adds configurable access latency with a BUSY stall handshake to the pipeline hazard unit.
- Adds a one-cycle READY completion pulse.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, minimum 4
LATENCY, 2, access latency in cycles; 0 = single-cycle, no stall
ADDR_WIDTH, 32, width of byte address input

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset
MEM_READ  input  1  load request (ID/EX -> EX/MEM control)
MEM_WRITE  input  1  store request
FUNCT3  input  3  RV32 load/store size and signedness
ADDR  input  ADDR_WIDTH  byte address from ALU
DATA_IN  input  32  store data (rs2)
DATA_OUT  output  32  load result, extended to 32 bits
BUSY  output  1  combinational stall request to pipeline
READY  output  1  one-cycle pulse: access completed
MISALIGNED  output  1  one-cycle pulse with READY on a rejected access

Behaviour:
- Clock CLK; reset RESET, synchronous, active-high.
- Reset: all memory words = 0, DATA_OUT = 0, READY = 0, MISALIGNED = 0, state = IDLE, counter = 0.
- RESET mid-access aborts the access: no write, no READY.
- Word index = ADDR[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4. Byte lanes are little-endian by ADDR[1:0].
- A request is MEM_READ or MEM_WRITE. If both are high, the write takes priority and DATA_OUT is unchanged.
- Loads:
  - 000 LB: byte, sign-extended
  - 001 LH: half, sign-extended
  - 010 LW: word
  - 100 LBU: byte, zero-extended
  - 101 LHU: half, zero-extended
  - Other funct3 values return 0.
- Stores:
  - 000 SB: write only the addressed byte
  - 001 SH: write the addressed half (ADDR[1] selects)
  - 010 SW: write the full word
  - Other funct3 values: no write.
- DATA_OUT is registered. It updates only on load completion and holds its value otherwise; stores never change it.
- LATENCY = 0:
  - FSM stays IDLE; BUSY is always 0.
  - The access is performed at the request edge; DATA_OUT is valid the following cycle.
  - READY pulses the cycle after each request.
- LATENCY >= 1, FSM IDLE -> WAIT -> DONE:
  - IDLE: BUSY = request. On an edge with a request, latch ADDR, FUNCT3, DATA_IN and the op.
    - If LATENCY = 1: perform the access and go to DONE.
    - Otherwise: counter <= LATENCY-1 and go to WAIT.
  - WAIT: BUSY = 1. On each edge, if counter = 1, perform the access from the latched values and go to DONE; otherwise decrement the counter.
  - DONE: BUSY = 0, READY = 1, requests ignored. Always returns to IDLE next edge. The stalled pipeline advances at this edge, so a held request is never re-issued.
- BUSY is high for exactly LATENCY consecutive cycles per access. Input changes after latching are ignored.

Optional Feature:
Macro: DMEM_MISALIGN_CHECK_EN
- Defined: an access is misaligned if it is LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=0.
  - The access is rejected: no write, and for loads DATA_OUT = 0.
  - MISALIGNED pulses in the same cycle as READY; timing and BUSY are unchanged.
- Undefined: low address bits are forced to alignment (ADDR[0] for half, ADDR[1:0] for word) and the access proceeds normally. MISALIGNED is tied 0.

Test Plan:
All scenarios use DEPTH=256, LATENCY=2 unless stated.
1. Release RESET; LW @0 -> BUSY high for 2 cycles, READY pulse in the 3rd cycle, DATA_OUT=0x00000000.
2. SW 0x8899AABB @40, then loads:
   - LB @41 -> 0xFFFFFFAA
   - LBU @41 -> 0x000000AA
   - LH @42 -> 0xFFFF8899
   - LHU @42 -> 0x00008899
   - LW @40 -> 0x8899AABB
3. After (2): SB 0x12 @43 -> LW @40 = 0x1299AABB. Then SH 0x3344 @40 -> LW @40 = 0x12993344. DATA_OUT does not change during the stores.
4. Wrap: SW 0x00000055 @0x400 -> LW @0x000 = 0x00000055.
5. RESET asserted during WAIT of SW 0xDEADBEEF @8 -> next cycle BUSY=0, READY never pulses, LW @8 = 0. With LATENCY=0: back-to-back SW 0x1234 @4 then LW @4 -> BUSY always 0, DATA_OUT=0x00001234 the cycle after the LW.
6. LW @2 after SW 0xCAFEF00D @0:
   - With DMEM_MISALIGN_CHECK_EN: MISALIGNED and READY pulse together, DATA_OUT=0.
   - Without: DATA_OUT=0xCAFEF00D, MISALIGNED=0.
